// File: rtl/ibex_l2_rf_responder.sv
// Backing-store half of the split register file: holds the words not cached in L1 and answers
// single-word read/write requests with a fixed-latency response pulse.
module ibex_l2_rf_responder #(
    parameter int DataWidth = 32,
    parameter int AddrWidth = 5,
    parameter int NumWords  = 32,
    parameter int Latency   = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  logic                 req_we_i,
    input  logic [AddrWidth-1:0] req_addr_i,
    input  logic [DataWidth-1:0] req_wdata_i,
    output logic                 rsp_valid_o,
    output logic                 rsp_we_o,
    output logic [DataWidth-1:0] rsp_rdata_o,
    output logic                 rsp_err_o,
    output logic                 busy_o
);

    localparam int                 IdxWidth  = (NumWords > 1) ? $clog2(NumWords) : 1;
    localparam int                 CntWidth  = 4;
    localparam logic [AddrWidth:0] NumWordsL = (AddrWidth + 1)'(NumWords);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StWait = 2'd1,
        StResp = 2'd2
    } state_e;

    state_e                 state_q;
    logic [CntWidth-1:0]    cnt_q;
    logic                   we_q;
    logic [AddrWidth-1:0]   addr_q;
    logic [DataWidth-1:0]   wdata_q;
    logic                   err_q;
    logic                   rsp_valid_q;
    logic                   rsp_we_q;
    logic                   rsp_err_q;
    logic [DataWidth-1:0]   rsp_rdata_q;
    logic [DataWidth-1:0]   mem_q [NumWords];

    logic                   sel_we;
    logic [AddrWidth-1:0]   sel_addr;
    logic                   sel_err;
    logic [DataWidth-1:0]   sel_rdata;
    logic                   commit;

    // Fields of the request whose response is launched at the coming edge: the latched one
    // when leaving WAIT, the incoming one when Latency is 1.
    always_comb begin
        sel_we    = (state_q == StWait) ? we_q   : req_we_i;
        sel_addr  = (state_q == StWait) ? addr_q : req_addr_i;
        sel_err   = ({1'b0, sel_addr} >= NumWordsL);
        commit    = (state_q == StResp) && we_q && !err_q && (addr_q != '0);
        sel_rdata = '0;
        if (!sel_we && !sel_err && (sel_addr != '0)) begin
            // A write retiring at this same edge must be visible to the read launched here.
            if (commit && (addr_q == sel_addr)) begin
                sel_rdata = wdata_q;
            end else begin
                sel_rdata = mem_q[sel_addr[IdxWidth-1:0]];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            err_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_we_q    <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
            for (int i = 0; i < NumWords; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (commit) begin
                mem_q[addr_q[IdxWidth-1:0]] <= wdata_q;
            end
            rsp_valid_q <= 1'b0;
            rsp_we_q    <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
            unique case (state_q)
                StIdle, StResp: begin
                    if (req_valid_i) begin
                        we_q    <= req_we_i;
                        addr_q  <= req_addr_i;
                        wdata_q <= req_wdata_i;
                        err_q   <= sel_err;
                        if (Latency == 1) begin
                            state_q     <= StResp;
                            rsp_valid_q <= 1'b1;
                            rsp_we_q    <= sel_we;
                            rsp_err_q   <= sel_err;
                            rsp_rdata_q <= sel_rdata;
                        end else begin
                            state_q <= StWait;
                            cnt_q   <= CntWidth'(Latency - 1);
                        end
                    end else begin
                        state_q <= StIdle;
                    end
                end
                StWait: begin
                    if (cnt_q <= CntWidth'(1)) begin
                        state_q     <= StResp;
                        cnt_q       <= '0;
                        rsp_valid_q <= 1'b1;
                        rsp_we_q    <= sel_we;
                        rsp_err_q   <= sel_err;
                        rsp_rdata_q <= sel_rdata;
                    end else begin
                        cnt_q <= cnt_q - CntWidth'(1);
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign req_ready_o = (state_q != StWait);
    assign busy_o      = (state_q != StIdle);
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_we_o    = rsp_we_q;
    assign rsp_err_o   = rsp_err_q;
    assign rsp_rdata_o = rsp_rdata_q;

endmodule
